key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
- Input-side conditioner between the board pushbuttons (KEY[1:0], active-low: 1 = released, 0 = pressed) and the game FSM in top.
- Synchronises, debounces and edge-detects each key independently.
- Outputs a debounced level plus single-cycle press/release pulses, so each player action (hit/stand) is consumed exactly once per physical press.

Parameters:
- NUM_KEYS, 2, number of independent key channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a change (10 ms at 50 MHz). Must be >= 2. Benches override it to 4.
- CNT_W, $clog2(DEBOUNCE_CYCLES), local counter width, not overridable.

Ports:
- CLOCK_50  input  1  system clock, all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- KEY  input  NUM_KEYS  raw asynchronous pushbuttons, active-low.
- key_pressed  output  NUM_KEYS  debounced level, 1 = key held.
- key_press_pulse  output  NUM_KEYS  1-cycle pulse on accepted press.
- key_release_pulse  output  NUM_KEYS  1-cycle pulse on accepted release.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high.
- Reset values: both synchroniser flops per key = 1 (released); FSM = RELEASED; counter = 0; all outputs = 0. All outputs are registered.
- Synchroniser: 2 flops per key (s1, s2). FSM sees only s2.
- Per-key FSM states and transitions:
  - RELEASED: s2 = 0 → PRESS_CHK, cnt = 0.
  - PRESS_CHK: s2 = 1 → RELEASED (bounce rejected, no pulse). s2 = 0 and cnt != DEBOUNCE_CYCLES-1 → cnt++. s2 = 0 and cnt == DEBOUNCE_CYCLES-1 → PRESSED; key_pressed = 1 and key_press_pulse = 1 on the same edge.
  - PRESSED: s2 = 1 → RELEASE_CHK, cnt = 0.
  - RELEASE_CHK: s2 = 0 → PRESSED (no pulse, key_pressed stays 1). s2 = 1 and cnt != DEBOUNCE_CYCLES-1 → cnt++. s2 = 1 and cnt == DEBOUNCE_CYCLES-1 → RELEASED; key_pressed = 0 and key_release_pulse = 1 on the same edge.
- Pulses are high for exactly one cycle. They are never asserted in consecutive cycles for the same key.
- Latency: let edge k be the first edge where s1 captures a stable new value.
  - PRESS_CHK/RELEASE_CHK is entered at edge k+2.
  - The pulse and level change occur at edge k+DEBOUNCE_CYCLES+2 (k+6 when DEBOUNCE_CYCLES = 4).
- Bounce: any glitch reaching s2 and lasting fewer than DEBOUNCE_CYCLES+1 cycles produces no pulse and no level change. The counter restarts from 0 on the next qualifying transition.
- Counter: saturation is not required. It never exceeds DEBOUNCE_CYCLES-1 and resets to 0 on every CHK entry.
- Channels are fully independent. Simultaneous presses on several keys yield pulses on the same cycle.
- Reset mid-operation: FSM, counter and outputs return to reset values immediately. No release pulse is emitted for a key that was PRESSED.
- Key held through reset deassertion: it is re-detected as a fresh press after full debounce latency, with exactly one press pulse.
- KEY bits change asynchronously to CLOCK_50. No combinational path from KEY to any output.

Test Plan (DEBOUNCE_CYCLES = 4, NUM_KEYS = 2):
- Reset then idle with KEY = 2'b11 for 20 cycles → all outputs 0 throughout; outputs 0 asynchronously while reset is high.
- KEY[0] driven 0 just before edge k and held 20 cycles → key_press_pulse[0] = 1 for exactly the cycle after edge k+6; key_pressed[0] = 1 from edge k+6; channel 1 unchanged.
- From PRESSED, KEY[0] released (1) and held → key_release_pulse[0] one cycle at edge k'+6; key_pressed[0] = 0 from the same edge.
- Bounce: KEY[1] low 3 cycles, high 2, low 2, high 10 → no pulses and key_pressed[1] stays 0. Then hold low 10 cycles → exactly one press pulse.
- KEY = 2'b00 applied on the same edge → key_press_pulse = 2'b11 on the same cycle, 6 edges later.
- Reset asserted 2 cycles after key_pressed[0] = 1, with KEY[0] still held, then deasserted → outputs 0 during reset, no release pulse; one press pulse at edge r+6 after the first post-reset edge r.

Source files
------------

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises, debounces and edge-detects active-low pushbuttons.
// Each key channel is independent: 2-flop synchroniser, 4-state debounce FSM
// with a stability counter, registered level and single-cycle press/release pulses.
// Ports:
//   CLOCK_50          - system clock, rising edge
//   reset             - asynchronous, active-high reset
//   KEY               - raw asynchronous pushbuttons (0 = pressed)
//   key_pressed       - debounced level, 1 = key held
//   key_press_pulse   - one-cycle pulse on an accepted press
//   key_release_pulse - one-cycle pulse on an accepted release
module key_conditioner #(
  parameter int unsigned NUM_KEYS        = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic [NUM_KEYS-1:0] key_press_pulse,
  output logic [NUM_KEYS-1:0] key_release_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  logic [NUM_KEYS-1:0] s1_q, s1_d;
  logic [NUM_KEYS-1:0] s2_q, s2_d;
  state_t              state_q [NUM_KEYS];
  state_t              state_d [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];
  logic [NUM_KEYS-1:0] pressed_q, pressed_d;
  logic [NUM_KEYS-1:0] press_pulse_q, press_pulse_d;
  logic [NUM_KEYS-1:0] release_pulse_q, release_pulse_d;

  // Next-state: synchroniser shift plus per-key debounce FSM
  always_comb begin
    s1_d            = KEY;
    s2_d            = s1_q;
    pressed_d       = pressed_q;
    press_pulse_d   = '0;
    release_pulse_d = '0;
    for (int k = 0; k < int'(NUM_KEYS); k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      case (state_q[k])
        RELEASED: begin
          if (!s2_q[k]) begin
            state_d[k] = PRESS_CHK;
            cnt_d[k]   = '0;
          end
        end
        PRESS_CHK: begin
          // Any return to released before the count completes is a bounce
          if (s2_q[k]) begin
            state_d[k] = RELEASED;
          end else if (cnt_q[k] == CNT_LAST) begin
            state_d[k]       = PRESSED;
            pressed_d[k]     = 1'b1;
            press_pulse_d[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (s2_q[k]) begin
            state_d[k] = RELEASE_CHK;
            cnt_d[k]   = '0;
          end
        end
        RELEASE_CHK: begin
          if (!s2_q[k]) begin
            state_d[k] = PRESSED;
          end else if (cnt_q[k] == CNT_LAST) begin
            state_d[k]         = RELEASED;
            pressed_d[k]       = 1'b0;
            release_pulse_d[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_W'(1);
          end
        end
        default: begin
          state_d[k] = RELEASED;
          cnt_d[k]   = '0;
        end
      endcase
    end
  end

  // State registers; synchroniser resets to "released" so no false press
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      s1_q            <= '1;
      s2_q            <= '1;
      pressed_q       <= '0;
      press_pulse_q   <= '0;
      release_pulse_q <= '0;
      for (int k = 0; k < int'(NUM_KEYS); k++) begin
        state_q[k] <= RELEASED;
        cnt_q[k]   <= '0;
      end
    end else begin
      s1_q            <= s1_d;
      s2_q            <= s2_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      for (int k = 0; k < int'(NUM_KEYS); k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  assign key_pressed       = pressed_q;
  assign key_press_pulse   = press_pulse_q;
  assign key_release_pulse = release_pulse_q;

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed and random stimulus for key_conditioner with
// DEBOUNCE_CYCLES = 4, checked every cycle against a run-length debounce model.
module tb_key_conditioner;

  localparam int unsigned NK = 2;
  localparam int unsigned DB = 4;

  logic          clk;
  logic          reset;
  logic [NK-1:0] key;
  logic [NK-1:0] key_pressed;
  logic [NK-1:0] key_press_pulse;
  logic [NK-1:0] key_release_pulse;

  key_conditioner #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB)) dut (
    .CLOCK_50          (clk),
    .reset             (reset),
    .KEY               (key),
    .key_pressed       (key_pressed),
    .key_press_pulse   (key_press_pulse),
    .key_release_pulse (key_release_pulse)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: synchroniser delay line plus run length of disagreement
  logic [NK-1:0] m_s1, m_s2;
  bit            m_lvl [NK];
  int            m_run [NK];
  bit            m_pp  [NK];
  bit            m_rp  [NK];

  // Statistics on the DUT pulses within a directed phase
  int step_no;
  int n_press [NK];
  int n_rel   [NK];
  int first_press [NK];
  int first_rel   [NK];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = '1;
    m_s2 = '1;
    for (int i = 0; i < int'(NK); i++) begin
      m_lvl[i] = 1'b0;
      m_run[i] = 0;
      m_pp[i]  = 1'b0;
      m_rp[i]  = 1'b0;
    end
  endtask

  // A level change is accepted once the synchronised input has disagreed
  // with the debounced level for DB+1 consecutive edges.
  task automatic model_edge(input logic [NK-1:0] k_in);
    for (int i = 0; i < int'(NK); i++) begin
      bit raw_pressed;
      raw_pressed = !m_s2[i];
      m_pp[i] = 1'b0;
      m_rp[i] = 1'b0;
      if (raw_pressed != m_lvl[i]) m_run[i]++;
      else m_run[i] = 0;
      if (m_run[i] == int'(DB) + 1) begin
        m_lvl[i] = raw_pressed;
        if (raw_pressed) m_pp[i] = 1'b1;
        else m_rp[i] = 1'b1;
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = k_in;
  endtask

  task automatic clr_stats();
    step_no = 0;
    for (int i = 0; i < int'(NK); i++) begin
      n_press[i] = 0; n_rel[i] = 0; first_press[i] = 0; first_rel[i] = 0;
    end
  endtask

  // Drive KEY away from the edge, advance one edge, compare against the model
  task automatic step(input logic [NK-1:0] k_in);
    logic [7:0] e_lvl, e_pp, e_rp;
    key = k_in;
    @(posedge clk);
    model_edge(k_in);
    #1;
    step_no++;
    e_lvl = '0; e_pp = '0; e_rp = '0;
    for (int i = 0; i < int'(NK); i++) begin
      e_lvl[i] = m_lvl[i];
      e_pp[i]  = m_pp[i];
      e_rp[i]  = m_rp[i];
      if (key_press_pulse[i]) begin
        n_press[i]++;
        if (first_press[i] == 0) first_press[i] = step_no;
      end
      if (key_release_pulse[i]) begin
        n_rel[i]++;
        if (first_rel[i] == 0) first_rel[i] = step_no;
      end
    end
    check("pressed", 8'(key_pressed), e_lvl);
    check("press_pulse", 8'(key_press_pulse), e_pp);
    check("release_pulse", 8'(key_release_pulse), e_rp);
  endtask

  task automatic hold(input logic [NK-1:0] k_in, input int n);
    for (int i = 0; i < n; i++) step(k_in);
  endtask

  task automatic do_reset();
    #4;
    reset = 1'b1;
    #1;
    check("rst_async_lvl", 8'(key_pressed), 8'h00);
    check("rst_async_pulse", 8'({key_press_pulse, key_release_pulse}), 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_out", 8'({key_pressed, key_press_pulse, key_release_pulse}), 8'h00);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int wait_cnt;
    int hold_left [NK];
    logic [NK-1:0] rkey;

    reset = 1'b1;
    key   = 2'b11;
    model_reset();
    clr_stats();
    #5;
    do_reset();

    // Idle: everything stays low
    clr_stats();
    hold(2'b11, 20);
    check("idle_press_cnt", 8'(n_press[0] + n_press[1]), 8'd0);

    // Press key 0: pulse on the 7th step (edge k+6), channel 1 untouched
    clr_stats();
    hold(2'b10, 20);
    check("k0_press_lat", 8'(first_press[0]), 8'd7);
    check("k0_press_cnt", 8'(n_press[0]), 8'd1);
    check("k1_quiet", 8'(n_press[1] + n_rel[1]), 8'd0);

    // Release key 0
    clr_stats();
    hold(2'b11, 20);
    check("k0_rel_lat", 8'(first_rel[0]), 8'd7);
    check("k0_rel_cnt", 8'(n_rel[0]), 8'd1);

    // Bounce on key 1 is rejected, then a clean press is accepted once
    clr_stats();
    hold(2'b01, 3);
    hold(2'b11, 2);
    hold(2'b01, 2);
    hold(2'b11, 10);
    check("bounce_no_press", 8'(n_press[1]), 8'd0);
    check("bounce_no_rel", 8'(n_rel[1]), 8'd0);
    clr_stats();
    hold(2'b01, 10);
    check("k1_press_cnt", 8'(n_press[1]), 8'd1);
    check("k1_press_lat", 8'(first_press[1]), 8'd7);
    hold(2'b11, 20);

    // Simultaneous press on both keys
    clr_stats();
    hold(2'b00, 10);
    check("both_lat0", 8'(first_press[0]), 8'd7);
    check("both_lat1", 8'(first_press[1]), 8'd7);
    hold(2'b11, 20);

    // Reset while key 0 is held: no release pulse, fresh press afterwards
    wait_cnt = 0;
    while (!key_pressed[0] && wait_cnt < 30) begin
      step(2'b10);
      wait_cnt++;
    end
    check("hold_reached", 8'(key_pressed[0]), 8'd1);
    hold(2'b10, 2);
    key = 2'b10;
    do_reset();
    clr_stats();
    hold(2'b10, 20);
    check("post_rst_rel", 8'(n_rel[0]), 8'd0);
    check("post_rst_press", 8'(n_press[0]), 8'd1);
    check("post_rst_lat", 8'(first_press[0]), 8'd7);

    // Random bouncing with per-key hold lengths around the debounce window
    rkey = 2'b11;
    for (int i = 0; i < int'(NK); i++) hold_left[i] = 0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < int'(NK); i++) begin
        if (hold_left[i] == 0) begin
          rkey[i]      = 1'($urandom_range(0, 1));
          hold_left[i] = int'($urandom_range(1, 9));
        end
        hold_left[i]--;
      end
      step(rkey);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
